// File: rtl/i2c_bus_monitor_if.sv
// Bundles the monitored I2C lines with the event-record valid/ready stream.
// The master side is the monitor; the slave side is the pads plus the event consumer.
interface i2c_bus_monitor_if;
    logic       scl_i;
    logic       sda_i;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_type;
    logic [7:0] evt_data;
    logic       evt_ack;

    modport master (
        input  scl_i, sda_i, evt_ready,
        output evt_valid, evt_type, evt_data, evt_ack
    );

    modport slave (
        output scl_i, sda_i, evt_ready,
        input  evt_valid, evt_type, evt_data, evt_ack
    );
endinterface

// File: rtl/i2c_bus_monitor.sv
// Passive I2C monitor: synchronise and deglitch SCL/SDA, decode START/RSTART/BYTE/STOP/ERROR
// records and queue them in a first-word-fall-through FIFO.
module i2c_bus_monitor #(
    parameter int SYNC_LAT   = 2,
    parameter int FILTER_LEN = 3,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clock,
    input  logic                              rst_n,
    input  logic                              enable,
    input  logic                              clr_ovf,
    i2c_bus_monitor_if.master                 bus,
    output logic                              bus_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              overflow
);
    localparam int FC_W  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [2:0] EV_START  = 3'd1;
    localparam logic [2:0] EV_RSTART = 3'd2;
    localparam logic [2:0] EV_BYTE   = 3'd3;
    localparam logic [2:0] EV_STOP   = 3'd4;
    localparam logic [2:0] EV_ERROR  = 3'd5;

    typedef enum logic {IDLE, ACTIVE} state_t;

    // p0: synchronisers
    logic [SYNC_LAT-1:0] scl_sync_p0, sda_sync_p0;
    logic [1:0]          raw_p0;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_p0 <= '1;
            sda_sync_p0 <= '1;
        end else begin
            scl_sync_p0 <= {scl_sync_p0[SYNC_LAT-2:0], bus.scl_i};
            sda_sync_p0 <= {sda_sync_p0[SYNC_LAT-2:0], bus.sda_i};
        end
    end

    assign raw_p0 = {sda_sync_p0[SYNC_LAT-1], scl_sync_p0[SYNC_LAT-1]};

    // p1/p2: glitch filter (index 0 = SCL, 1 = SDA) and its one-cycle-delayed copy
    logic [1:0]      filt_p1, filt_p2;
    logic [FC_W-1:0] fcnt_p1 [2];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            filt_p1    <= '1;
            filt_p2    <= '1;
            fcnt_p1[0] <= '0;
            fcnt_p1[1] <= '0;
        end else begin
            filt_p2 <= filt_p1;
            for (int i = 0; i < 2; i++) begin
                if (raw_p0[i] == filt_p1[i]) begin
                    fcnt_p1[i] <= '0;
                end else if (fcnt_p1[i] == FC_W'(FILTER_LEN - 1)) begin
                    filt_p1[i] <= raw_p0[i];
                    fcnt_p1[i] <= '0;
                end else begin
                    fcnt_p1[i] <= fcnt_p1[i] + FC_W'(1);
                end
            end
        end
    end

    // p3: bus conditions; an SCL rise masks any simultaneous SDA change
    logic scl_hold, start_c, stop_c, bit_c;
    logic bit_p3, start_p3, stop_p3, sda_p3;

    assign scl_hold = filt_p1[0] & filt_p2[0];
    assign bit_c    = filt_p1[0] & ~filt_p2[0];
    assign start_c  = scl_hold & filt_p2[1] & ~filt_p1[1];
    assign stop_c   = scl_hold & ~filt_p2[1] & filt_p1[1];

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            bit_p3   <= 1'b0;
            start_p3 <= 1'b0;
            stop_p3  <= 1'b0;
            sda_p3   <= 1'b1;
        end else begin
            bit_p3   <= bit_c;
            start_p3 <= start_c;
            stop_p3  <= stop_c;
            sda_p3   <= filt_p1[1];
        end
    end

    // Decoder FSM
    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        push;
    logic [11:0] push_rec;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_p3) begin
                        state_nxt = ACTIVE;
                        cnt_nxt   = '0;
                    end
                end
                ACTIVE: begin
                    if (bit_p3) begin
                        if (cnt == 4'd8) begin
                            cnt_nxt = '0;
                        end else begin
                            shreg_nxt = {shreg[6:0], sda_p3};
                            cnt_nxt   = cnt + 4'd1;
                        end
                    end else if (start_p3) begin
                        cnt_nxt = '0;
                    end else if (stop_p3) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Record layout: {type[2:0], data[7:0], ack}
    always_comb begin
        push     = 1'b0;
        push_rec = '0;
        if (enable && state == ACTIVE) begin
            if (bit_p3 && cnt == 4'd8) begin
                push     = 1'b1;
                push_rec = {EV_BYTE, shreg, ~sda_p3};
            end else if (start_p3 || stop_p3) begin
                push = 1'b1;
                if (cnt != 4'd0)
                    push_rec = {EV_ERROR, 4'd0, cnt, 1'b0};
                else
                    push_rec = {start_p3 ? EV_RSTART : EV_STOP, 8'd0, 1'b0};
            end
        end else if (enable && start_p3) begin
            push     = 1'b1;
            push_rec = {EV_START, 8'd0, 1'b0};
        end
    end

    assign bus_busy = (state == ACTIVE);

    // p4: registered push feeding the FIFO
    logic        push_vld_p4;
    logic [11:0] push_rec_p4;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            push_vld_p4 <= 1'b0;
            push_rec_p4 <= '0;
        end else begin
            push_vld_p4 <= push;
            push_rec_p4 <= push_rec;
        end
    end

    // Event FIFO; a push into a full FIFO is accepted when the head is popped the same cycle
    logic [11:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic             valid, full, pop, wr_ok;

    assign valid = (level != '0);
    assign full  = (level == LVL_W'(FIFO_DEPTH));
    assign pop   = valid & bus.evt_ready;
    assign wr_ok = push_vld_p4 & (~full | pop);

    always_ff @(posedge clock) begin
        if (wr_ok)
            mem[wr_ptr] <= push_rec_p4;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_ok, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (push_vld_p4 & full & ~pop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    assign fifo_level    = level;
    assign bus.evt_valid = valid;
    assign {bus.evt_type, bus.evt_data, bus.evt_ack} = valid ? mem[rd_ptr] : 12'd0;
endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Bench for i2c_bus_monitor: drives I2C bus symbols and compares popped events against a
// transaction-level reference model built from the decoding rules.
module tb_i2c_bus_monitor;
    localparam int S     = 2;
    localparam int F     = 3;
    localparam int D     = 8;
    localparam int LVL_W = $clog2(D + 1);

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             clr_ovf = 1'b0;
    logic             bus_busy;
    logic             overflow;
    logic [LVL_W-1:0] fifo_level;

    i2c_bus_monitor_if bus ();

    i2c_bus_monitor #(.SYNC_LAT(S), .FILTER_LEN(F), .FIFO_DEPTH(D)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .enable     (enable),
        .clr_ovf    (clr_ovf),
        .bus        (bus),
        .bus_busy   (bus_busy),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    logic [11:0] got_q[$];
    logic [11:0] exp_q[$];

    // Reference model state: transaction-level view of the bus
    bit m_en     = 1'b1;
    bit m_active = 1'b0;
    bit m_ovf    = 1'b0;
    bit m_bits[$];

    always @(negedge clock) begin
        if (bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1)
            got_q.push_back({bus.evt_type, bus.evt_data, bus.evt_ack});
    end

    function automatic void push_exp(int t, int d, bit a);
        logic [11:0] rec;
        rec = {t[2:0], d[7:0], a};
        if (bus.evt_ready !== 1'b1 && exp_q.size() >= D)
            m_ovf = 1'b1;
        else
            exp_q.push_back(rec);
    endfunction

    function automatic void m_bit(bit b);
        int v;
        if (!m_en || !m_active) return;
        if (m_bits.size() < 8) begin
            m_bits.push_back(b);
        end else begin
            v = 0;
            for (int i = 0; i < 8; i++) v = v * 2 + int'(m_bits[i]);
            push_exp(3, v, !b);
            m_bits.delete();
        end
    endfunction

    function automatic void m_sda(bit v);
        if (!m_en) return;
        if (v == 1'b0) begin
            if (!m_active) push_exp(1, 0, 1'b0);
            else if (m_bits.size() == 0) push_exp(2, 0, 1'b0);
            else push_exp(5, m_bits.size(), 1'b0);
            m_active = 1'b1;
            m_bits.delete();
        end else if (m_active) begin
            if (m_bits.size() == 0) push_exp(4, 0, 1'b0);
            else push_exp(5, m_bits.size(), 1'b0);
            m_active = 1'b0;
            m_bits.delete();
        end
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic hold();
        repeat (F + 2 + int'($urandom_range(0, 3))) step();
    endtask

    task automatic clk_bit(bit b);
        bus.scl_i = 1'b0;
        hold();
        bus.sda_i = b;
        hold();
        bus.scl_i = 1'b1;
        m_bit(b);
        hold();
    endtask

    task automatic sda_set(bit v);
        if (bus.sda_i !== v) begin
            bus.sda_i = v;
            m_sda(v);
        end
        hold();
    endtask

    task automatic send_byte(logic [7:0] d, bit ack);
        for (int i = 7; i >= 0; i--) clk_bit(d[i]);
        clk_bit(!ack);
    endtask

    task automatic finish_xfer();
        if (bus.sda_i == 1'b0) begin
            sda_set(1'b1);
        end else begin
            sda_set(1'b0);
            sda_set(1'b1);
        end
    endtask

    task automatic glitch(int n);
        bus.sda_i = 1'b0;
        repeat (n) step();
        bus.sda_i = 1'b1;
        if (n >= F) begin
            m_sda(1'b0);
            m_sda(1'b1);
        end
        hold();
    endtask

    task automatic compare_events(string tag);
        repeat (16) step();
        chk({tag, ".count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s.evt%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, ".busy"}, 32'(bus_busy), 32'(m_active));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int  lat;
        bit  found;
        bit  aborted;
        int  nb;

        bus.scl_i     = 1'b1;
        bus.sda_i     = 1'b1;
        bus.evt_ready = 1'b1;
        enable        = 1'b1;
        rst_n         = 1'b0;
        repeat (3) step();
        chk("rst.valid", 32'(bus.evt_valid), 32'(0));
        chk("rst.type", 32'(bus.evt_type), 32'(0));
        chk("rst.data", 32'(bus.evt_data), 32'(0));
        chk("rst.ack", 32'(bus.evt_ack), 32'(0));
        chk("rst.busy", 32'(bus_busy), 32'(0));
        chk("rst.level", 32'(fifo_level), 32'(0));
        chk("rst.ovf", 32'(overflow), 32'(0));
        rst_n = 1'b1;
        repeat (10) step();

        // Write 0xA6 with ACK then STOP, measuring START latency
        bus.sda_i = 1'b0;
        m_sda(1'b0);
        lat   = -1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            lat++;
            if (bus.evt_valid === 1'b1) found = 1'b1;
        end
        chk("latency", 32'(lat), 32'(S + F + 2));
        hold();
        send_byte(8'hA6, 1'b1);
        compare_events("wr_a6");
        sda_set(1'b1);
        compare_events("wr_a6_stop");

        // Repeated START between two bytes
        sda_set(1'b0);
        send_byte(8'h50, 1'b0);
        sda_set(1'b0);
        send_byte(8'h51, 1'b1);
        sda_set(1'b1);
        compare_events("rstart");

        // Aborted transfer after 3 bits
        sda_set(1'b0);
        clk_bit(1'b1);
        clk_bit(1'b0);
        clk_bit(1'b0);
        sda_set(1'b1);
        compare_events("abort3");

        // Glitch filter
        glitch(F - 1);
        compare_events("glitch_short");
        glitch(F);
        compare_events("glitch_long");

        // Overflow with consumer stalled
        bus.evt_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            sda_set(1'b0);
            sda_set(1'b1);
        end
        repeat (16) step();
        chk("ovf.level", 32'(fifo_level), 32'(exp_q.size()));
        chk("ovf.flag", 32'(overflow), 32'(m_ovf));
        bus.evt_ready = 1'b1;
        compare_events("ovf_drain");
        chk("ovf.sticky", 32'(overflow), 32'(m_ovf));
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        m_ovf   = 1'b0;
        step();
        chk("ovf.clear", 32'(overflow), 32'(m_ovf));

        // Reset in the middle of a byte
        sda_set(1'b0);
        clk_bit(1'b1);
        clk_bit(1'b0);
        compare_events("pre_reset");
        bus.scl_i = 1'b0;
        hold();
        rst_n = 1'b0;
        step();
        m_active = 1'b0;
        m_bits.delete();
        chk("midrst.busy", 32'(bus_busy), 32'(m_active));
        chk("midrst.level", 32'(fifo_level), 32'(exp_q.size()));
        step();
        rst_n = 1'b1;
        hold();
        for (int i = 0; i < 6; i++) clk_bit(1'(i % 2));
        clk_bit(1'b0);
        sda_set(1'b1);
        compare_events("post_reset");

        // Decoder disabled for a whole transfer
        enable   = 1'b0;
        m_en     = 1'b0;
        m_active = 1'b0;
        hold();
        sda_set(1'b0);
        send_byte(8'($urandom), 1'b1);
        compare_events("disabled_mid");
        sda_set(1'b1);
        compare_events("disabled_end");
        enable = 1'b1;
        m_en   = 1'b1;
        hold();

        // Randomised transfers
        for (int t = 0; t < 6; t++) begin
            sda_set(1'b0);
            nb      = int'($urandom_range(1, 2));
            aborted = 1'b0;
            for (int b = 0; b < nb && !aborted; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    for (int k = 0; k < int'($urandom_range(1, 7)); k++)
                        clk_bit(1'($urandom_range(0, 1)));
                    aborted = 1'b1;
                end else begin
                    send_byte(8'($urandom), 1'($urandom_range(0, 1)));
                end
            end
            finish_xfer();
            compare_events($sformatf("rand%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
